uart_tx_word_serializer: RTL and testbench
==========================================

// Module: uart_tx_word_serializer
//
// PURPOSE
//   Splits one NBITS word from the debug controller into NBITS/BYTE_WIDTH bytes and feeds them,
//   one at a time, to the byte-wide UART transmitter. It sits between the debug controller's
//   tx_Data/tx_start/tx_done interface and the UART TX core's byte_Data/byte_tx_start/
//   byte_tx_done handshake. It returns a single tx_done pulse per word, so PC, DM, RB and
//   clock-count dumps each leave the board as complete words.
//
// PARAMETERS
//   NBITS       32  word width accepted from the debug controller; multiple of BYTE_WIDTH
//   BYTE_WIDTH   8  width of each byte handed to the UART TX core
//   LSB_FIRST    1  1: least-significant byte sent first; 0: most-significant byte first
//
// PORTS
//   clk            in   1           system clock; all state updates on rising edge
//   reset          in   1           asynchronous, active-low reset (0 = reset)
//   tx_Data        in   NBITS       word to transmit; sampled only when a word is accepted
//   tx_start       in   1           level request from debug controller; held high until tx_done
//   byte_tx_done   in   1           1-cycle pulse from UART TX core: current byte fully shifted out
//   byte_Data      out  BYTE_WIDTH  byte presented to the UART TX core
//   byte_tx_start  out  1           1-cycle pulse: UART TX core launches byte_Data
//   tx_done        out  1           1-cycle pulse: all bytes of the accepted word sent
//   busy           out  1           high from word acceptance until return to IDLE
//
// BEHAVIOUR
//   Reset (reset==0, any time, including mid-word):
//     - state=IDLE; byte_Data=0; byte_tx_start=0; tx_done=0; busy=0; word register=0; byte_cnt=0.
//     - Any partial word is discarded. No tx_done is issued for it.
//   All outputs are registered.
//
//   The FSM has four states:
//     IDLE:  if tx_start==1, load tx_Data into the word register, set byte_cnt=0 and busy=1,
//            then go to SEND. byte_tx_done is ignored in this state.
//     SEND:  set byte_Data to byte byte_cnt of the word, assert byte_tx_start for exactly
//            one cycle, then go to WAIT.
//            With LSB_FIRST=1, byte k = word[k*BYTE_WIDTH +: BYTE_WIDTH].
//            With LSB_FIRST=0, byte k = word[NBITS-1-k*BYTE_WIDTH -: BYTE_WIDTH].
//     WAIT:  on byte_tx_done:
//              - if byte_cnt==NBITS/BYTE_WIDTH-1: set tx_done=1 (one cycle) and go to REARM.
//              - otherwise: byte_cnt++ and go to SEND.
//            With no byte_tx_done, stay in WAIT indefinitely (no timeout).
//     REARM: tx_done returns to 0. Stay in REARM while tx_start==1.
//            When tx_start==0, clear busy and go to IDLE.
//            This prevents a held-high tx_start from re-sending the same word.
//
//   Timing:
//     - The first byte_tx_start is asserted 2 clocks after tx_start is first sampled high in IDLE.
//     - tx_done is asserted 1 clock after the last byte_tx_done.
//     - The minimum gap between two accepted words is 1 cycle of tx_start low.
//   byte_Data stays stable from its SEND cycle until the next SEND or reset, so it meets the
//   UART core's hold requirement.
//   The word is captured once at acceptance. Changes to tx_Data while busy have no effect.
//   byte_tx_done is a don't-care when it arrives in SEND or REARM; it does not advance byte_cnt.
//   byte_cnt width is clog2(NBITS/BYTE_WIDTH), minimum 1. It never wraps past the last byte.
//
// TESTING
//   1. LSB_FIRST=1, tx_Data=32'h11223344, tx_start held high, UART model acks each byte
//      after 10 cycles -> byte_Data sequence 44,33,22,11; exactly 4 byte_tx_start pulses;
//      one tx_done pulse.
//   2. After test 1, keep tx_start high for 20 more cycles -> no further byte_tx_start;
//      drop tx_start for 1 cycle, raise it with 32'hDEADBEEF -> bytes EF,BE,AD,DE.
//   3. Change tx_Data to 32'hFFFFFFFF after byte 1 of 32'h0000A5A5 -> bytes A5,A5,00,00.
//   4. Pulse reset low while in WAIT after byte 2 -> all outputs 0, busy=0, no tx_done;
//      the next word is sent in full from byte 0.
//   5. Pulse byte_tx_done in IDLE and in REARM -> no state change, no byte_tx_start,
//      no tx_done.
//   6. LSB_FIRST=0, tx_Data=32'h10001000 -> bytes 10,00,10,00; tx_done 1 clock after the
//      4th ack.

Source files
------------

// File: rtl/uart_tx_word_serializer_if.sv
// Handshake bundle between the debug controller, the word serializer and the byte-wide UART TX.
// The slave modport is the serializer's view. The master modport is the view of whatever drives it.
interface uart_tx_word_serializer_if #(
    parameter int unsigned NBITS      = 32,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic [NBITS-1:0]      tx_Data;
    logic                  tx_start;
    logic                  tx_done;
    logic                  busy;
    logic [BYTE_WIDTH-1:0] byte_Data;
    logic                  byte_tx_start;
    logic                  byte_tx_done;

    modport slave (
        input  tx_Data,
        input  tx_start,
        input  byte_tx_done,
        output tx_done,
        output busy,
        output byte_Data,
        output byte_tx_start
    );

    modport master (
        output tx_Data,
        output tx_start,
        output byte_tx_done,
        input  tx_done,
        input  busy,
        input  byte_Data,
        input  byte_tx_start
    );
endinterface

// File: rtl/uart_tx_word_serializer.sv
// Splits one NBITS word into BYTE_WIDTH bytes for a byte-wide UART TX core.
// It returns one tx_done pulse per word. All outputs are registered.
module uart_tx_word_serializer #(
    parameter int unsigned NBITS      = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input logic                      clk,
    input logic                      reset,
    uart_tx_word_serializer_if.slave bus
);

    localparam int unsigned NumBytes = NBITS / BYTE_WIDTH;
    localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StRearm
    } state_e;

    state_e                state_q, state_d;
    logic [NBITS-1:0]      word_q, word_d;
    logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
    logic [BYTE_WIDTH-1:0] byte_data_q, byte_data_d;
    logic                  byte_start_q, byte_start_d;
    logic                  tx_done_q, tx_done_d;
    logic                  busy_q, busy_d;

    logic [CntW-1:0]       byte_idx;
    logic [BYTE_WIDTH-1:0] cur_byte;

    // The byte index is mirrored for MSB-first order, so one mux serves both orders.
    always_comb begin
        byte_idx = LSB_FIRST ? byte_cnt_q : LastCnt - byte_cnt_q;
        cur_byte = '0;
        for (int unsigned k = 0; k < NumBytes; k++) begin
            if (byte_idx == CntW'(k)) begin
                cur_byte = word_q[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        byte_data_d  = byte_data_q;
        byte_start_d = 1'b0;
        tx_done_d    = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            StIdle: begin
                if (bus.tx_start) begin
                    word_d     = bus.tx_Data;
                    byte_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                byte_data_d  = cur_byte;
                byte_start_d = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                if (bus.byte_tx_done) begin
                    if (byte_cnt_q == LastCnt) begin
                        tx_done_d = 1'b1;
                        state_d   = StRearm;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = StSend;
                    end
                end
            end
            StRearm: begin
                // A held-high request must drop before the next word is accepted.
                if (!bus.tx_start) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            byte_data_q  <= '0;
            byte_start_q <= 1'b0;
            tx_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_data_q  <= byte_data_d;
            byte_start_q <= byte_start_d;
            tx_done_q    <= tx_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.byte_Data     = byte_data_q;
    assign bus.byte_tx_start = byte_start_q;
    assign bus.tx_done       = tx_done_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Directed bench for uart_tx_word_serializer: an LSB-first and an MSB-first instance,
// each with a UART model that acknowledges every byte 10 cycles after its start pulse.
module tb_uart_tx_word_serializer;

    localparam int ACK_DLY = 10;
    localparam int BUDGET  = 200;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_word_serializer_if #(.NBITS(32), .BYTE_WIDTH(8)) bus_l ();
    uart_tx_word_serializer_if #(.NBITS(32), .BYTE_WIDTH(8)) bus_m ();

    logic auto_l, auto_m, man_l;
    assign bus_l.byte_tx_done = auto_l | man_l;
    assign bus_m.byte_tx_done = auto_m;

    uart_tx_word_serializer #(.NBITS(32), .BYTE_WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_l)
    );

    uart_tx_word_serializer #(.NBITS(32), .BYTE_WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_m)
    );

    // Byte loggers
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    int starts_l = 0, dones_l = 0, starts_m = 0, dones_m = 0;
    int done_cyc_m = 0, ack_cyc_m = 0;

    always @(negedge clk) begin
        if (bus_l.byte_tx_start) begin
            q_l.push_back(bus_l.byte_Data);
            starts_l++;
        end
        if (bus_l.tx_done) dones_l++;
        if (bus_m.byte_tx_start) begin
            q_m.push_back(bus_m.byte_Data);
            starts_m++;
        end
        if (bus_m.tx_done) begin
            dones_m++;
            done_cyc_m = cyc;
        end
    end

    // UART models
    initial begin
        auto_l = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_l.byte_tx_start && rst_n) begin
                repeat (ACK_DLY - 1) @(negedge clk);
                auto_l = 1'b1;
                @(negedge clk);
                auto_l = 1'b0;
            end
        end
    end

    initial begin
        auto_m = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_m.byte_tx_start && rst_n) begin
                repeat (ACK_DLY - 1) @(negedge clk);
                auto_m    = 1'b1;
                ack_cyc_m = cyc;
                @(negedge clk);
                auto_m = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input bit msb, input string tag, input int base,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp[4];
        logic [31:0] obs;
        exp = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            if (!msb) obs = (base + i < q_l.size()) ? {24'h0, q_l[base+i]} : 32'hxxxxxxxx;
            else      obs = (base + i < q_m.size()) ? {24'h0, q_m[base+i]} : 32'hxxxxxxxx;
            check($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp[i]});
        end
    endtask

    task automatic wait_dones_l(input int want, input string tag);
        for (int i = 0; i < BUDGET && dones_l < want; i++) @(negedge clk);
        check(tag, dones_l, want);
    endtask

    task automatic wait_starts_l(input int want, input string tag);
        for (int i = 0; i < BUDGET && starts_l < want; i++) @(negedge clk);
        check(tag, starts_l, want);
    endtask

    int sb, db, qb;

    initial begin
        rst_n          = 1'b0;
        man_l          = 1'b0;
        bus_l.tx_start = 1'b0;
        bus_l.tx_Data  = '0;
        bus_m.tx_start = 1'b0;
        bus_m.tx_Data  = '0;
        repeat (3) @(negedge clk);
        check("rst_byte_data", bus_l.byte_Data, 0);
        check("rst_byte_start", bus_l.byte_tx_start, 0);
        check("rst_tx_done", bus_l.tx_done, 0);
        check("rst_busy", bus_l.busy, 0);
        check("rst_busy_m", bus_m.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: LSB-first word with tx_start held high
        sb = starts_l; db = dones_l; qb = q_l.size();
        bus_l.tx_Data  = 32'h11223344;
        bus_l.tx_start = 1'b1;
        @(negedge clk);
        check("t1_busy_on_accept", bus_l.busy, 1);
        check("t1_no_start_in_send", bus_l.byte_tx_start, 0);
        @(negedge clk);
        check("t1_first_start", bus_l.byte_tx_start, 1);
        check("t1_first_byte", bus_l.byte_Data, 32'h44);
        wait_dones_l(db + 1, "t1_tx_done");
        check_bytes(1'b0, "t1", qb, 8'h44, 8'h33, 8'h22, 8'h11);
        check("t1_start_pulses", starts_l - sb, 4);
        check("t1_byte_hold", bus_l.byte_Data, 32'h11);

        // 2: held tx_start must not re-send; 1-cycle gap then a new word
        sb = starts_l;
        repeat (20) @(negedge clk);
        check("t2_no_resend", starts_l - sb, 0);
        check("t2_single_done", dones_l, db + 1);
        check("t2_busy_rearm", bus_l.busy, 1);
        bus_l.tx_start = 1'b0;
        @(negedge clk);
        check("t2_busy_clear", bus_l.busy, 0);
        db = dones_l; qb = q_l.size();
        bus_l.tx_Data  = 32'hDEADBEEF;
        bus_l.tx_start = 1'b1;
        wait_dones_l(db + 1, "t2_tx_done");
        check_bytes(1'b0, "t2", qb, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        bus_l.tx_start = 1'b0;
        repeat (2) @(negedge clk);

        // 3: tx_Data changes while busy
        sb = starts_l; db = dones_l; qb = q_l.size();
        bus_l.tx_Data  = 32'h0000A5A5;
        bus_l.tx_start = 1'b1;
        wait_starts_l(sb + 1, "t3_first_start");
        bus_l.tx_Data = 32'hFFFFFFFF;
        wait_dones_l(db + 1, "t3_tx_done");
        check_bytes(1'b0, "t3", qb, 8'hA5, 8'hA5, 8'h00, 8'h00);
        bus_l.tx_start = 1'b0;
        repeat (2) @(negedge clk);

        // 4: reset in WAIT after byte 2
        sb = starts_l; db = dones_l;
        bus_l.tx_Data  = 32'h55667788;
        bus_l.tx_start = 1'b1;
        wait_starts_l(sb + 2, "t4_two_starts");
        repeat (3) @(negedge clk);
        rst_n          = 1'b0;
        bus_l.tx_start = 1'b0;
        @(negedge clk);
        check("t4_rst_byte_data", bus_l.byte_Data, 0);
        check("t4_rst_byte_start", bus_l.byte_tx_start, 0);
        check("t4_rst_tx_done", bus_l.tx_done, 0);
        check("t4_rst_busy", bus_l.busy, 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_no_done", dones_l, db);
        check("t4_no_more_starts", starts_l - sb, 2);
        qb = q_l.size();
        bus_l.tx_Data  = 32'hCAFEF00D;
        bus_l.tx_start = 1'b1;
        wait_dones_l(db + 1, "t4_tx_done");
        check_bytes(1'b0, "t4", qb, 8'h0D, 8'hF0, 8'hFE, 8'hCA);
        bus_l.tx_start = 1'b0;
        repeat (2) @(negedge clk);

        // 5: stray byte_tx_done in IDLE and in REARM
        sb = starts_l; db = dones_l;
        man_l = 1'b1;
        @(negedge clk);
        man_l = 1'b0;
        check("t5_idle_no_start", bus_l.byte_tx_start, 0);
        check("t5_idle_no_done", bus_l.tx_done, 0);
        check("t5_idle_busy", bus_l.busy, 0);
        repeat (2) @(negedge clk);
        check("t5_idle_start_count", starts_l - sb, 0);
        qb = q_l.size();
        bus_l.tx_Data  = 32'h01020304;
        bus_l.tx_start = 1'b1;
        wait_dones_l(db + 1, "t5_tx_done");
        check_bytes(1'b0, "t5", qb, 8'h04, 8'h03, 8'h02, 8'h01);
        @(negedge clk);
        sb = starts_l;
        man_l = 1'b1;
        @(negedge clk);
        man_l = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rearm_no_start", starts_l - sb, 0);
        check("t5_rearm_no_done", dones_l, db + 1);
        check("t5_rearm_busy", bus_l.busy, 1);
        bus_l.tx_start = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_back_idle", bus_l.busy, 0);

        // 6: MSB-first instance
        sb = starts_m; db = dones_m; qb = q_m.size();
        bus_m.tx_Data  = 32'h10001000;
        bus_m.tx_start = 1'b1;
        for (int i = 0; i < BUDGET && dones_m < db + 1; i++) @(negedge clk);
        check("t6_tx_done", dones_m, db + 1);
        check_bytes(1'b1, "t6", qb, 8'h10, 8'h00, 8'h10, 8'h00);
        check("t6_start_pulses", starts_m - sb, 4);
        check("t6_done_latency", done_cyc_m - ack_cyc_m, 1);
        bus_m.tx_start = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
